// File: rtl/digit_demux_pkg.sv
// digit_demux shared types and sizes.
// Digit count, index width, FSM states, watchdog counter width.
package digit_demux_pkg;

  localparam int NDIG  = 4;
  localparam int IDX_W = 2;
  localparam int CNT_W = 8;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic {
    HUNT,
    COLLECT
  } state_t;

  localparam idx_t LAST_IDX = idx_t'(NDIG - 1);

endpackage

// File: rtl/digit_demux_if.sv
// digit_demux scanned-bus interface.
// master drives the scan slot + err_clr; slave returns digits and status.
interface digit_demux_if #(
  parameter int DW = 4
);

  logic [DW-1:0] in_digit;
  logic [1:0]    in_bit;
  logic          in_en;
  logic          err_clr;

  logic [DW-1:0] out0;
  logic [DW-1:0] out1;
  logic [DW-1:0] out2;
  logic [DW-1:0] out3;
  logic          frame_done;
  logic          seq_err;
  logic          seq_err_sticky;
  logic          stall;

  modport master (
    output in_digit, in_bit, in_en, err_clr,
    input  out0, out1, out2, out3,
    input  frame_done, seq_err, seq_err_sticky, stall
  );

  modport slave (
    input  in_digit, in_bit, in_en, err_clr,
    output out0, out1, out2, out3,
    output frame_done, seq_err, seq_err_sticky, stall
  );

endinterface

// File: rtl/digit_demux_wdog.sv
// Scan-stall watchdog: counts repeats of the accepted index.
// In: clk, sys_rst_n, s_idx, s_vld. Out: stall (cnt >= TIMEOUT).
module digit_demux_wdog
  import digit_demux_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic sys_rst_n,
  input  idx_t s_idx,
  input  logic s_vld,
  output logic stall
);

  logic [CNT_W-1:0] cnt;
  idx_t             prev;
  logic             seen;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt  <= '0;
      prev <= '0;
      seen <= 1'b0;
    end else if (s_vld) begin
      seen <= 1'b1;
      prev <= s_idx;
      if (!seen || s_idx != prev)
        cnt <= '0;
      else if (cnt != '1)
        cnt <= cnt + 1'b1;
    end
  end

  assign stall = (cnt >= CNT_W'(TIMEOUT));

endmodule

// File: rtl/digit_demux.sv
// digit_demux: rebuilds four parallel digits from a scanned digit bus.
// Ports: clk, sys_rst_n, bus (digit_demux_if.slave). Macro: DIGIT_DEMUX_SEQ_CHECK_EN.
module digit_demux
  import digit_demux_pkg::*;
#(
  parameter int DW      = 4,
  parameter int TIMEOUT = 8
) (
  input logic          clk,
  input logic          sys_rst_n,
  digit_demux_if.slave bus
);

  logic [DW-1:0] s_digit;
  idx_t          s_idx;
  logic          s_vld;

  logic [DW-1:0] sh [NDIG];
  logic [DW-1:0] outs [NDIG];

  logic stall;
  logic publish;
  logic err;
  logic frame_done;
  logic seq_err;
  logic sticky;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s_digit <= '0;
      s_idx   <= '0;
      s_vld   <= 1'b0;
    end else begin
      s_digit <= bus.in_digit;
      s_idx   <= bus.in_bit;
      s_vld   <= bus.in_en;
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < NDIG; i++)
        sh[i] <= '0;
    end else if (s_vld) begin
      sh[s_idx] <= s_digit;
    end
  end

  digit_demux_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .s_idx     (s_idx),
    .s_vld     (s_vld),
    .stall     (stall)
  );

`ifdef DIGIT_DEMUX_SEQ_CHECK_EN

  state_t state;
  state_t nxt;
  idx_t   exp_q;
  idx_t   exp_n;
  logic   stall_q;
  logic   stall_rise;

  assign stall_rise = stall && !stall_q;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= HUNT;
      exp_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      state   <= nxt;
      exp_q   <= exp_n;
      stall_q <= stall;
    end
  end

  // An out-of-order slot 0 restarts collection directly,
  // so the realigned frame loses no slot.
  always_comb begin
    nxt   = state;
    exp_n = exp_q;
    if (stall_rise) begin
      nxt = HUNT;
    end else if (s_vld) begin
      unique case (state)
        HUNT: begin
          if (s_idx == '0) begin
            nxt   = COLLECT;
            exp_n = idx_t'(1);
          end
        end
        COLLECT: begin
          if (s_idx == exp_q) begin
            if (exp_q == LAST_IDX)
              nxt = HUNT;
            else
              exp_n = exp_q + 1'b1;
          end else if (s_idx == '0) begin
            nxt   = COLLECT;
            exp_n = idx_t'(1);
          end else begin
            nxt = HUNT;
          end
        end
      endcase
    end
  end

  always_comb begin
    publish = 1'b0;
    err     = 1'b0;
    if (!stall_rise && s_vld && state == COLLECT) begin
      if (s_idx == exp_q)
        publish = (exp_q == LAST_IDX);
      else
        err = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      sticky <= 1'b0;
    else if (err)
      sticky <= 1'b1;
    else if (bus.err_clr)
      sticky <= 1'b0;
  end

`else

  logic unused_err_clr;

  assign unused_err_clr = bus.err_clr;
  assign publish        = s_vld && (s_idx == LAST_IDX);
  assign err            = 1'b0;
  assign sticky         = 1'b0;

`endif

  // Slot 3 bypasses its shadow so the frame publishes one edge earlier.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < NDIG; i++)
        outs[i] <= '0;
      frame_done <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      frame_done <= publish;
      seq_err    <= err;
      if (publish) begin
        for (int i = 0; i < NDIG - 1; i++)
          outs[i] <= sh[i];
        outs[NDIG-1] <= s_digit;
      end
    end
  end

  assign bus.out0           = outs[0];
  assign bus.out1           = outs[1];
  assign bus.out2           = outs[2];
  assign bus.out3           = outs[3];
  assign bus.frame_done     = frame_done;
  assign bus.seq_err        = seq_err;
  assign bus.seq_err_sticky = sticky;
  assign bus.stall          = stall;

endmodule

// File: tb/tb_digit_demux.sv
// Directed bench for digit_demux with a frame scoreboard.
// Expected frames are queued at stimulus time, popped on frame_done.
module tb_digit_demux;

  logic clk = 1'b0;
  logic sys_rst_n = 1'b0;

  always #5 clk = ~clk;

  digit_demux_if #(.DW(4)) bus ();

  digit_demux #(
    .DW      (4),
    .TIMEOUT (8)
  ) dut (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fd_cnt = 0;
  int last_fd = -1;
  int prev_fd = -1;

  logic [15:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [15:0] outs();
    return {bus.out3, bus.out2, bus.out1, bus.out0};
  endfunction

  function automatic void expect_frame(input int a, input int b,
                                       input int c, input int d);
    exp_q.push_back({d[3:0], c[3:0], b[3:0], a[3:0]});
  endfunction

  always @(negedge clk) begin
    if (sys_rst_n && bus.frame_done === 1'b1) begin
      prev_fd <= last_fd;
      last_fd <= cyc;
      fd_cnt  <= fd_cnt + 1;
      if (exp_q.size() == 0)
        chk("unexpected_frame_done", 32'(exp_q.size()), 32'd1);
      else
        chk("frame", 32'(outs()), 32'(exp_q.pop_front()));
    end
  end

  task automatic slot(input int idx, input int dig);
    bus.in_en    = 1'b1;
    bus.in_bit   = idx[1:0];
    bus.in_digit = dig[3:0];
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.in_en = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    bus.in_en    = 1'b0;
    bus.in_bit   = 2'd0;
    bus.in_digit = 4'd0;
    bus.err_clr  = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", 32'(outs()), 32'h0);
    chk("rst_flags", 32'({bus.frame_done, bus.seq_err,
                          bus.seq_err_sticky, bus.stall}), 32'h0);
    sys_rst_n = 1'b1;
    idle(2);

    // single frame, latency and pulse width
    slot(0, 1);
    slot(1, 2);
    slot(2, 3);
    expect_frame(1, 2, 3, 4);
    slot(3, 4);
    chk("t1_not_early", 32'(bus.frame_done), 32'd0);
    idle(1);
    chk("t1_pulse", 32'(bus.frame_done), 32'd1);
    chk("t1_outs", 32'(outs()), 32'h4321);
    idle(1);
    chk("t1_pulse_end", 32'(bus.frame_done), 32'd0);
    chk("t1_hold", 32'(outs()), 32'h4321);

    // back-to-back frames
    expect_frame(2, 5, 3, 1);
    slot(0, 2);
    slot(1, 5);
    slot(2, 3);
    slot(3, 1);
    expect_frame(3, 9, 7, 3);
    slot(0, 3);
    slot(1, 9);
    slot(2, 7);
    slot(3, 3);
    idle(2);
    chk("t2_interval", 32'(last_fd - prev_fd), 32'd4);
    chk("t2_count", 32'(fd_cnt), 32'd3);
    chk("t2_outs", 32'(outs()), 32'h3793);

`ifdef DIGIT_DEMUX_SEQ_CHECK_EN
    // skipped index
    slot(0, 1);
    slot(1, 1);
    slot(3, 1);
    chk("seq_not_early", 32'(bus.seq_err), 32'd0);
    idle(1);
    chk("seq_pulse", 32'(bus.seq_err), 32'd1);
    chk("seq_sticky_set", 32'(bus.seq_err_sticky), 32'd1);
    idle(1);
    chk("seq_pulse_end", 32'(bus.seq_err), 32'd0);
    chk("seq_sticky_hold", 32'(bus.seq_err_sticky), 32'd1);
    chk("seq_outs_kept", 32'(outs()), 32'h3793);
    bus.err_clr = 1'b1;
    idle(1);
    bus.err_clr = 1'b0;
    chk("seq_sticky_clr", 32'(bus.seq_err_sticky), 32'd0);
`endif

    // stall: nine identical accepted indices
    repeat (9) slot(2, 6);
    chk("stall_boundary", 32'(bus.stall), 32'd0);
`ifndef DIGIT_DEMUX_SEQ_CHECK_EN
    expect_frame(3, 9, 6, 8);
`endif
    slot(3, 8);
    chk("stall_set", 32'(bus.stall), 32'd1);
    idle(1);
    chk("stall_clear", 32'(bus.stall), 32'd0);
    idle(2);

    // enable gap mid-frame
    slot(0, 5);
    slot(1, 6);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      chk("gap_no_stall", 32'(bus.stall), 32'd0);
    end
    expect_frame(5, 6, 7, 8);
    slot(2, 7);
    slot(3, 8);
    idle(2);
    chk("gap_outs", 32'(outs()), 32'h8765);

    // asynchronous reset mid-frame
    slot(0, 9);
    slot(1, 4);
    bus.in_en = 1'b0;
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", 32'(outs()), 32'h0);
    chk("mid_rst_flags", 32'({bus.frame_done, bus.seq_err,
                              bus.seq_err_sticky, bus.stall}), 32'h0);
    @(posedge clk);
    #1;
    sys_rst_n = 1'b1;
    idle(1);
`ifndef DIGIT_DEMUX_SEQ_CHECK_EN
    expect_frame(0, 0, 0, 5);
    slot(3, 5);
    idle(2);
    chk("rst_shadow_clear", 32'(outs()), 32'h5000);
`endif
    expect_frame(10, 11, 12, 13);
    slot(0, 10);
    slot(1, 11);
    slot(2, 12);
    slot(3, 13);
    idle(3);
    chk("post_rst_outs", 32'(outs()), 32'hdcba);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
